// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch control block.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_LAP   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      PAUSE = ST_PAUSE,
      LAP   = ST_LAP
   } sw_state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a button level that is already synchronous to clk.
module btn_edge (
   input  logic clk,
   input  logic reset,
   input  logic lvl_i,
   output logic rise_o
);

   logic prev_q;

   // History follows the level during reset so a button held through reset
   // is not mistaken for a fresh press once reset releases.
   always_ff @(posedge clk) begin
      if (reset) prev_q <= lvl_i;
      else       prev_q <= lvl_i;
   end

   assign rise_o = lvl_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: run/pause/lap/clear FSM, prescaled count strobe,
// lap-freeze display mux and sticky wrap flag.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_stop,
   input  logic             lap_reset,
   input  logic [WIDTH-1:0] timer_in,
   output logic             count_en,
   output logic             count_clr,
   output logic [WIDTH-1:0] display,
   output logic             running,
   output logic             frozen,
   output logic             overflow
);

   localparam int            PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   sw_state_t        state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] lap_q, lap_d;
   logic             cen_q, cen_d;
   logic             clr_q, clr_d;
   logic             ovf_q, ovf_d;
   logic             ss_edge, lr_edge, active;

   btn_edge u_ss_edge (.clk(clk), .reset(reset), .lvl_i(start_stop), .rise_o(ss_edge));
   btn_edge u_lr_edge (.clk(clk), .reset(reset), .lvl_i(lap_reset),  .rise_o(lr_edge));

   always_comb begin
      state_d = state_q;
      lap_d   = lap_q;
      clr_d   = 1'b0;
      active  = (state_q == RUN) || (state_q == LAP);

      // start_stop has priority; a simultaneous lap_reset edge is dropped.
      if (ss_edge) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            LAP:     state_d = PAUSE;
            default: state_d = IDLE;
         endcase
      end else if (lr_edge) begin
         case (state_q)
            RUN: begin
               state_d = LAP;
               lap_d   = timer_in;
            end
            LAP:     state_d = RUN;
            PAUSE: begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end
            default: state_d = state_q;
         endcase
      end

      // Paused intervals keep their partial progress; IDLE restarts from zero.
      pre_d = pre_q;
      if (state_q == IDLE)
         pre_d = '0;
      else if (active)
         pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);

      cen_d = active && (pre_q == PRE_MAX);

      ovf_d = ovf_q;
      if (cen_q && (timer_in == '1)) ovf_d = 1'b1;
      if (clr_d)                     ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pre_q   <= '0;
         lap_q   <= '0;
         cen_q   <= 1'b0;
         clr_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         lap_q   <= lap_d;
         cen_q   <= cen_d;
         clr_q   <= clr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign display   = (state_q == LAP) ? lap_q : timer_in;
   assign running   = (state_q == RUN) || (state_q == LAP);
   assign frozen    = (state_q == LAP);
   assign count_en  = cen_q;
   assign count_clr = clr_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with an external timer datapath model.
module tb_stopwatch_ctrl;

   localparam int W = 4;
   localparam int P = 4;
   localparam int TMOD = 1 << W;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_LAP   = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start_stop = 1'b0;
   logic         lap_reset = 1'b0;
   logic [W-1:0] timer_q = '0;
   logic         count_en, count_clr, running, frozen, overflow;
   logic [W-1:0] display;

   stopwatch_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .start_stop(start_stop), .lap_reset(lap_reset),
      .timer_in(timer_q), .count_en(count_en), .count_clr(count_clr),
      .display(display), .running(running), .frozen(frozen), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // External timer register driven by the DUT strobes.
   always @(posedge clk) begin
      if (count_clr === 1'b1)     timer_q <= '0;
      else if (count_en === 1'b1) timer_q <= timer_q + 1'b1;
   end

   typedef struct {
      int cen;
      int clr;
      int disp;
      int run;
      int frz;
      int ovf;
      int timer;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // Reference model: mode, elapsed cycles within the current interval, etc.
   int m_mode = M_IDLE;
   int m_elapsed = 0;
   int m_lap = 0;
   int m_cen = 0;
   int m_clr = 0;
   int m_ovf = 0;
   int m_timer = 0;
   int m_prev_ss = 0;
   int m_prev_lr = 0;

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic model_step(input int r, input int s, input int l);
      int   new_timer, e_ss, e_lr, counting;
      exp_t e;
      if (m_clr != 0)      new_timer = 0;
      else if (m_cen != 0) new_timer = (m_timer + 1) % TMOD;
      else                 new_timer = m_timer;
      if (r != 0) begin
         m_mode = M_IDLE; m_elapsed = 0; m_lap = 0;
         m_cen = 0; m_clr = 0; m_ovf = 0;
      end else begin
         e_ss = (s != 0 && m_prev_ss == 0) ? 1 : 0;
         e_lr = (l != 0 && m_prev_lr == 0 && e_ss == 0) ? 1 : 0;
         counting = (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0;
         if (m_cen != 0 && m_timer == TMOD - 1) m_ovf = 1;
         m_cen = (counting != 0 && m_elapsed + 1 == P) ? 1 : 0;
         if (counting != 0)          m_elapsed = (m_elapsed + 1) % P;
         else if (m_mode == M_IDLE)  m_elapsed = 0;
         m_clr = 0;
         if (e_ss != 0) begin
            if (m_mode == M_RUN || m_mode == M_LAP) m_mode = M_PAUSE;
            else                                    m_mode = M_RUN;
         end else if (e_lr != 0) begin
            if (m_mode == M_RUN) begin
               m_mode = M_LAP; m_lap = m_timer;
            end else if (m_mode == M_LAP) begin
               m_mode = M_RUN;
            end else if (m_mode == M_PAUSE) begin
               m_mode = M_IDLE; m_clr = 1; m_ovf = 0;
            end
         end
      end
      m_prev_ss = s;
      m_prev_lr = l;
      m_timer   = new_timer;
      e.cen   = m_cen;
      e.clr   = m_clr;
      e.disp  = (m_mode == M_LAP) ? m_lap : m_timer;
      e.run   = (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0;
      e.frz   = (m_mode == M_LAP) ? 1 : 0;
      e.ovf   = m_ovf;
      e.timer = m_timer;
      q.push_back(e);
   endtask

   task automatic cyc(input int r, input int s, input int l);
      @(negedge clk);
      #1;
      reset      = (r != 0);
      start_stop = (s != 0);
      lap_reset  = (l != 0);
      model_step(r, s, l);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0);
   endtask

   task automatic press_ss();
      cyc(0, 1, 0);
      cyc(0, 0, 0);
   endtask

   task automatic press_lr();
      cyc(0, 0, 1);
      cyc(0, 0, 0);
   endtask

   // Monitor: compare each registered response against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("count_en",  int'(count_en),  e.cen);
            chk("count_clr", int'(count_clr), e.clr);
            chk("display",   int'(display),   e.disp);
            chk("running",   int'(running),   e.run);
            chk("frozen",    int'(frozen),    e.frz);
            chk("overflow",  int'(overflow),  e.ovf);
            chk("timer",     int'(timer_q),   e.timer);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int s_lvl, l_lvl, r;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      // Start and run three full intervals.
      press_ss();
      idle(12);
      // Pause part-way through an interval, then resume.
      idle(1);
      press_ss();
      idle(10);
      press_ss();
      idle(8);
      // Lap freeze and release.
      press_lr();
      idle(8);
      press_lr();
      idle(4);
      // Pause, clear, and lap_reset while idle.
      press_ss();
      idle(3);
      press_lr();
      idle(3);
      press_lr();
      idle(3);
      // Long run through wrap, then pause/resume with sticky overflow.
      press_ss();
      idle(72);
      press_ss();
      idle(5);
      press_ss();
      idle(5);
      // Both buttons together while running.
      cyc(0, 1, 1);
      cyc(0, 0, 0);
      idle(4);
      // Held start_stop from PAUSE: a single resume.
      for (int i = 0; i < 20; i++) cyc(0, 1, 0);
      idle(6);
      // Reset while running.
      cyc(1, 0, 0);
      idle(6);
      // Randomised button activity.
      s_lvl = 0;
      l_lvl = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) s_lvl = 1 - s_lvl;
         if ($urandom_range(0, 6) == 0) l_lvl = 1 - l_lvl;
         r = ($urandom_range(0, 299) == 0) ? 1 : 0;
         cyc(r, s_lvl, l_lvl);
      end
      idle(3);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
